mopshub_test_sequencer: RTL and testbench
=========================================

// Module: mopshub_test_sequencer
// PURPOSE
//  Synthesisable multi-bus test sequencer; runs trim -> RX -> endwait -> gap -> TX -> custom-msg per CAN bus.
//  Iterates over every bus enabled in a mask, with per-phase enables, per-phase timeouts and pass/fail bookkeeping.
//  Sits between mopshub_top status strobes and the data_generator test request inputs.
//  Replaces the fixed single-bus always-block sequencing in the MOPSHUB bench.
// PARAMETERS
//  N_BUSES    32     number of CAN buses sequenced; 1..32
//  BUS_W      5      width of bus index; must satisfy 2**BUS_W >= N_BUSES
//  GAP_CYCLES 120    clk cycles between endwait_all pulse and TX request (3 us at 40 MHz); >=1
//  TMO_W      16     width of the phase timeout counter
//  CNT_W      8      width of the pass and fail counters
// PORTS
//  clk             in   1        40 MHz system clock
//  rst             in   1        synchronous reset, active-low
//  start           in   1        1-cycle strobe that starts a run (sign_on_sig)
//  abort           in   1        synchronous abort of a run in progress
//  bus_mask        in   N_BUSES  buses to test; latched at start
//  phase_en        in   4        phase enables {adv,tx,rx,trim}; latched at start
//  tmo_limit       in   TMO_W    maximum wait per phase in cycles; 0 means no timeout
//  trim_done       in   1        trim-complete strobe (trim_sig_done | done_trim_osc)
//  test_rx_end     in   1        RX-phase complete strobe
//  test_tx_end     in   1        TX-phase complete strobe
//  costum_msg_end  in   1        custom-message complete strobe
//  osc_auto_trim   out  1        trim request; level, held while in TRIM
//  test_rx         out  1        RX test request; level, held while in RX
//  test_tx         out  1        TX test request; level, held while in TX
//  test_advanced   out  1        custom-message request; level, held while in ADV
//  endwait_all     out  1        1-cycle pulse on RX completion
//  bus_id          out  BUS_W    index of the bus under test
//  busy            out  1        high from start accept until DONE
//  done            out  1        1-cycle pulse on run completion
//  fail_mask       out  N_BUSES  bit i set if any phase of bus i timed out
//  pass_cnt        out  CNT_W    buses completed without timeout; saturating
//  fail_cnt        out  CNT_W    phase timeouts over the run; saturating
// BEHAVIOUR
//  Reset (rst=0 at a clk edge)
//   - All outputs go to 0 and the FSM goes to IDLE, from any state.
//   - Counters and fail_mask are cleared.
//  FSM states: IDLE, SEL, TRIM, RX, EWAIT, GAP, TX, ADV, NEXT, DONE.
//  IDLE
//   - start=1 latches bus_mask and phase_en, clears fail_mask and both counters, sets busy, goes to SEL.
//   - start while busy is ignored.
//  SEL
//   - Picks the lowest masked bus index >= the current index and drives it on bus_id.
//   - The scan is combinational priority; one cycle in SEL.
//   - No remaining bus -> DONE. An all-zero mask gives DONE 2 cycles after start.
//  Phase order per bus: TRIM, RX, EWAIT, GAP, TX, ADV.
//   - A disabled phase is skipped with zero cycles.
//   - EWAIT and GAP exist only when RX is enabled.
//  Wait states (TRIM, RX, TX, ADV)
//   - The request output is high in the cycle after entry and stays high until exit.
//   - Exit is on the matching end strobe; the request drops on the next edge.
//   - End strobes that do not match the current state are ignored.
//  EWAIT: endwait_all high for exactly 1 cycle, then GAP.
//  GAP: stays exactly GAP_CYCLES cycles, then TX (or ADV/NEXT if those phases are disabled).
//  Timeout
//   - The phase counter resets on entry to each wait state.
//   - If tmo_limit != 0 and the counter reaches tmo_limit before the end strobe:
//     set fail_mask[bus_id], increment fail_cnt, drop the request, go to NEXT.
//   - The remaining phases of that bus are skipped.
//   - An end strobe in the same cycle as the limit counts as success; no fail is recorded.
//  NEXT
//   - Increments pass_cnt if fail_mask[bus_id]==0.
//   - bus_id == N_BUSES-1 -> DONE; otherwise bus_id+1 -> SEL.
//  DONE: done high for 1 cycle, busy cleared, go to IDLE. fail_mask and counters hold until the next start.
//  Abort
//   - abort=1 in any non-IDLE state returns the FSM to IDLE at the next edge.
//   - All requests and busy drop at that edge; done is not pulsed.
//   - Counters and fail_mask hold their values.
//   - abort and start in the same cycle: abort wins.
//  Saturation: pass_cnt and fail_cnt stop at 2**CNT_W-1 and do not wrap.
// TESTING
//  1. N_BUSES=4, mask=4'b0101, phase_en=4'b1111, strobes returned after 10 cycles
//     -> bus_id 0 then 2, one endwait_all per bus, TX rises 120 cycles after each endwait, pass_cnt=2, done.
//  2. mask=4'b0010, tmo_limit=20, test_rx_end never asserted
//     -> test_rx drops after 20 cycles, fail_mask=4'b0010, fail_cnt=1, TX/ADV never asserted, done.
//  3. test_rx_end asserted on the exact cycle the counter reaches tmo_limit -> treated as pass, fail_cnt=0.
//  4. phase_en=4'b0100 (TX only), mask=4'b1111
//     -> no trim, RX or endwait activity; four TX requests, pass_cnt=4.
//  5. abort during GAP of bus 1 -> next edge: all requests 0, busy=0, no done; a later start runs from bus 0.
//  6. rst=0 asserted mid-TX -> next edge: all outputs 0; mask=0 then start -> done 2 cycles after start.

Source files
------------

// File: rtl/mopshub_test_sequencer.sv
// Multi-bus CAN test sequencer: walks every bus in a latched mask through
// trim -> RX -> endwait -> gap -> TX -> custom-msg with per-phase timeouts.
module mopshub_test_sequencer #(
    parameter int N_BUSES    = 32,
    parameter int BUS_W      = 5,
    parameter int GAP_CYCLES = 120,
    parameter int TMO_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_BUSES-1:0] bus_mask,
    input  logic [3:0]         phase_en,
    input  logic [TMO_W-1:0]   tmo_limit,
    input  logic               trim_done,
    input  logic               test_rx_end,
    input  logic               test_tx_end,
    input  logic               costum_msg_end,
    output logic               osc_auto_trim,
    output logic               test_rx,
    output logic               test_tx,
    output logic               test_advanced,
    output logic               endwait_all,
    output logic [BUS_W-1:0]   bus_id,
    output logic               busy,
    output logic               done,
    output logic [N_BUSES-1:0] fail_mask,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CW    = (TMO_W > GAP_W) ? TMO_W : GAP_W;

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_TRIM, S_RX, S_EWAIT, S_GAP, S_TX, S_ADV, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nx;
    state_t             nx_trim, nx_rx, nx_tx, nx_adv;
    logic [N_BUSES-1:0] mask_q;
    logic [3:0]         en_q;
    logic [BUS_W-1:0]   bus_q;
    logic [CW-1:0]      cnt;
    logic [BUS_W-1:0]   sel_idx;
    logic               sel_found;
    logic               tmo_hit;
    logic               fail_evt;

    // Lowest masked index at or above the current bus; descending loop so the
    // last hit (smallest index) wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_BUSES - 1; i >= 0; i--) begin
            if (mask_q[i] && (BUS_W'(i) >= bus_q)) begin
                sel_found = 1'b1;
                sel_idx   = BUS_W'(i);
            end
        end
    end

    // Successor of each phase when the phases after it may be disabled.
    always_comb begin
        nx_adv  = en_q[3] ? S_ADV : S_NEXT;
        nx_tx   = en_q[2] ? S_TX  : nx_adv;
        nx_rx   = en_q[1] ? S_RX  : nx_tx;
        nx_trim = en_q[0] ? S_TRIM : nx_rx;
    end

    // cnt is 1 in the first cycle of a state, so a match with the limit
    // means the state has lasted exactly that many cycles.
    assign tmo_hit = (tmo_limit != '0) && (cnt == CW'(tmo_limit));

    always_comb begin
        state_nx = state;
        fail_evt = 1'b0;
        case (state)
            S_IDLE:  if (start && !abort) state_nx = S_SEL;
            S_SEL:   state_nx = sel_found ? nx_trim : S_DONE;
            S_TRIM: begin
                if (trim_done)    state_nx = nx_rx;
                else if (tmo_hit) begin state_nx = S_NEXT; fail_evt = 1'b1; end
            end
            S_RX: begin
                if (test_rx_end)  state_nx = S_EWAIT;
                else if (tmo_hit) begin state_nx = S_NEXT; fail_evt = 1'b1; end
            end
            S_EWAIT: state_nx = S_GAP;
            S_GAP:   if (cnt == CW'(GAP_CYCLES)) state_nx = nx_tx;
            S_TX: begin
                if (test_tx_end)  state_nx = nx_adv;
                else if (tmo_hit) begin state_nx = S_NEXT; fail_evt = 1'b1; end
            end
            S_ADV: begin
                if (costum_msg_end) state_nx = S_NEXT;
                else if (tmo_hit)   begin state_nx = S_NEXT; fail_evt = 1'b1; end
            end
            S_NEXT:  state_nx = (bus_q == BUS_W'(N_BUSES - 1)) ? S_DONE : S_SEL;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            fail_evt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mask_q    <= '0;
            en_q      <= '0;
            bus_q     <= '0;
            fail_mask <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? CW'(1) : cnt + CW'(1);
            if ((state == S_IDLE) && (state_nx == S_SEL)) begin
                mask_q    <= bus_mask;
                en_q      <= phase_en;
                bus_q     <= '0;
                fail_mask <= '0;
                pass_cnt  <= '0;
                fail_cnt  <= '0;
            end
            if ((state == S_SEL) && sel_found && (state_nx != S_IDLE))
                bus_q <= sel_idx;
            if ((state == S_NEXT) && (state_nx == S_SEL))
                bus_q <= bus_q + BUS_W'(1);
            if (fail_evt) begin
                fail_mask[bus_q] <= 1'b1;
                if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
            end
            if ((state == S_NEXT) && (state_nx != S_IDLE) && !fail_mask[bus_q] &&
                (pass_cnt != {CNT_W{1'b1}}))
                pass_cnt <= pass_cnt + CNT_W'(1);
        end
    end

    assign osc_auto_trim = (state == S_TRIM);
    assign test_rx       = (state == S_RX);
    assign test_tx       = (state == S_TX);
    assign test_advanced = (state == S_ADV);
    assign endwait_all   = (state == S_EWAIT);
    assign done          = (state == S_DONE);
    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign bus_id        = bus_q;
endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: a strobe responder plus a timeline model
// that predicts every request pulse, counters and the done time of a run.
module tb_mopshub_test_sequencer;
    localparam int N   = 4;
    localparam int BW  = 2;
    localparam int G   = 120;
    localparam int TW  = 16;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;
    localparam int TRW = 37;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  bus_mask = '0;
    logic [3:0]    phase_en = '0;
    logic [TW-1:0] tmo_limit = '0;
    logic          trim_done, test_rx_end, test_tx_end, costum_msg_end;
    logic          osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all;
    logic [BW-1:0] bus_id;
    logic          busy, done;
    logic [N-1:0]  fail_mask;
    logic [CW-1:0] pass_cnt, fail_cnt;

    mopshub_test_sequencer #(
        .N_BUSES(N), .BUS_W(BW), .GAP_CYCLES(G), .TMO_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bus_mask(bus_mask), .phase_en(phase_en), .tmo_limit(tmo_limit),
        .trim_done(trim_done), .test_rx_end(test_rx_end),
        .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end),
        .osc_auto_trim(osc_auto_trim), .test_rx(test_rx), .test_tx(test_tx),
        .test_advanced(test_advanced), .endwait_all(endwait_all),
        .bus_id(bus_id), .busy(busy), .done(done), .fail_mask(fail_mask),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int run_c0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: strobe k fires in the dly-th cycle its request is high
    // (dly 0 = never); idle strobes toggle randomly and must be ignored.
    int       dly [N][4];
    int       hi [4];
    logic [3:0] strb = '0;
    logic [3:0] req;
    bit       noise_en = 1'b0;
    assign req = {test_advanced, test_tx, test_rx, osc_auto_trim};
    assign {costum_msg_end, test_tx_end, test_rx_end, trim_done} = strb;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req[k] === 1'b1) begin
                hi[k]   = hi[k] + 1;
                strb[k] = (hi[k] == dly[bus_id][k]);
            end else begin
                hi[k]   = 0;
                strb[k] = noise_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    function automatic logic [TRW-1:0] mk_tr(input int k, input int b, input int off, input int len);
        return {k[2:0], b[1:0], off[15:0], len[15:0]};
    endfunction

    // Monitor: one record per request/endwait pulse {kind, bus, start offset, length}.
    logic [TRW-1:0] obs_q[$];
    logic [TRW-1:0] exp_q[$];
    logic [4:0]     prev = '0;
    int             rise_c [5];
    logic [BW-1:0]  rise_b [5];
    bit             done_seen = 1'b0;
    int             done_c = 0;

    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {endwait_all, req};
        for (int k = 0; k < 5; k++) begin
            if (cur[k] === 1'b1 && !prev[k]) begin
                rise_c[k] = cyc;
                rise_b[k] = bus_id;
            end else if (cur[k] !== 1'b1 && prev[k]) begin
                obs_q.push_back(mk_tr(k, int'(rise_b[k]), rise_c[k] - run_c0, cyc - rise_c[k]));
            end
        end
        prev = (cur === 5'bxxxxx) ? 5'b0 : cur;
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_c    = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_dly(input int v);
        for (int b = 0; b < N; b++)
            for (int k = 0; k < 4; k++) dly[b][k] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " osc_auto_trim"}, osc_auto_trim, 0);
        chk({tag, " test_rx"}, test_rx, 0);
        chk({tag, " test_tx"}, test_tx, 0);
        chk({tag, " test_advanced"}, test_advanced, 0);
        chk({tag, " endwait_all"}, endwait_all, 0);
        chk({tag, " bus_id"}, bus_id, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " fail_mask"}, fail_mask, 0);
        chk({tag, " pass_cnt"}, pass_cnt, 0);
        chk({tag, " fail_cnt"}, fail_cnt, 0);
    endtask

    // Timeline model: cycle offsets counted from the start cycle; one cycle
    // of SEL before each bus, one of NEXT after it, EWAIT plus G gap cycles
    // after a successful RX.
    task automatic model(input logic [N-1:0] m, input logic [3:0] e, input int t,
                         output int done_off, output int pc, output int fc,
                         output logic [N-1:0] fm);
        int  cur, len, d;
        bit  failed;
        exp_q.delete();
        cur = 2; pc = 0; fc = 0; fm = '0;
        for (int b = 0; b < N; b++) begin
            if (!m[b]) continue;
            failed = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!e[k] || failed) continue;
                d = dly[b][k];
                if (t != 0 && (d == 0 || d > t)) begin
                    len = t;
                    failed = 1'b1;
                end else begin
                    len = d;
                end
                exp_q.push_back(mk_tr(k, b, cur, len));
                cur += len;
                if (k == 1 && !failed) begin
                    exp_q.push_back(mk_tr(4, b, cur, 1));
                    cur += 1 + G;
                end
            end
            if (failed) begin fm[b] = 1'b1; fc++; end
            else pc++;
            cur += (b == N - 1) ? 1 : 2;
        end
        done_off = cur;
        if (pc > SAT) pc = SAT;
        if (fc > SAT) fc = SAT;
    endtask

    task automatic run(input logic [N-1:0] m, input logic [3:0] e, input int t,
                       input bit poke, input string tag);
        int           exp_done, pc, fc, waited;
        logic [N-1:0] fm;
        model(m, e, t, exp_done, pc, fc, fm);
        bus_mask  = m;
        phase_en  = e;
        tmo_limit = TW'(t);
        obs_q.delete();
        done_seen = 1'b0;
        start  = 1'b1;
        run_c0 = cyc;
        step();
        start = 1'b0;
        if (exp_done > 2) chk({tag, " busy after start"}, busy, 1);
        waited = 1;
        while (!done_seen && waited < 20000) begin
            step();
            waited++;
            start = poke && (waited == 4) && (exp_done > 8);
        end
        start = 1'b0;
        chk({tag, " done seen"}, done_seen, 1);
        chk({tag, " done offset"}, done_c - run_c0, exp_done);
        chk({tag, " busy at done"}, busy, 0);
        chk({tag, " n_events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s ev%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
        chk({tag, " pass_cnt"}, pass_cnt, pc);
        chk({tag, " fail_cnt"}, fail_cnt, fc);
        chk({tag, " fail_mask"}, fail_mask, fm);
        step();
        chk({tag, " done one cycle"}, done, 0);
    endtask

    initial begin
        int w;
        set_dly(5);
        rst = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b1;
        noise_en = 1'b1;
        step();

        // Two buses, all phases, strobes after 10 cycles.
        set_dly(10);
        run(4'b0101, 4'b1111, 0, 1'b0, "t1");

        // RX never answers: timeout after 20 cycles, remaining phases skipped.
        set_dly(5);
        dly[1][1] = 0;
        run(4'b0010, 4'b1111, 20, 1'b0, "t2");

        // End strobe on the very cycle the limit is reached is a pass; one later is a fail.
        set_dly(7);
        run(4'b0001, 4'b0010, 7, 1'b0, "t3_pass");
        set_dly(8);
        run(4'b0001, 4'b0010, 7, 1'b0, "t3_fail");

        // TX only on every bus; pass_cnt saturates.
        set_dly(4);
        run(4'b1111, 4'b0100, 0, 1'b1, "t4");

        // Every trim times out; fail_cnt saturates.
        set_dly(0);
        run(4'b1111, 4'b0001, 3, 1'b0, "fail_sat");

        // Empty mask: done two cycles after start.
        run(4'b0000, 4'b1111, 0, 1'b0, "empty");

        // Abort in the gap of bus 1.
        set_dly(3);
        bus_mask = 4'b0011; phase_en = 4'b1111; tmo_limit = '0;
        start = 1'b1; step(); start = 1'b0;
        w = 0;
        while (!(endwait_all === 1'b1 && bus_id == 2'd1) && w < 5000) begin step(); w++; end
        chk("abort reached gap", w < 5000, 1);
        repeat (5) step();
        done_seen = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort test_rx", test_rx, 0);
        chk("abort test_tx", test_tx, 0);
        chk("abort test_advanced", test_advanced, 0);
        chk("abort osc_auto_trim", osc_auto_trim, 0);
        chk("abort busy", busy, 0);
        chk("abort pass_cnt held", pass_cnt, 1);
        chk("abort fail_mask held", fail_mask, 0);
        repeat (10) step();
        chk("abort no done", done_seen, 0);
        chk("abort stays idle", test_tx, 0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("start+abort busy", busy, 0);
        step();
        chk("start+abort still idle", busy, 0);
        run(4'b0011, 4'b0100, 0, 1'b0, "after_abort");

        // Reset mid-TX of bus 1, then an empty run.
        set_dly(3);
        dly[1][2] = 0;
        bus_mask = 4'b0011; phase_en = 4'b0100; tmo_limit = '0;
        start = 1'b1; step(); start = 1'b0;
        w = 0;
        while (!(test_tx === 1'b1 && bus_id == 2'd1) && w < 5000) begin step(); w++; end
        chk("reset reached tx", w < 5000, 1);
        chk("reset pre pass_cnt", pass_cnt, 1);
        step();
        rst = 1'b0; step(); rst = 1'b1;
        chk_all_zero("mid_tx_reset");
        step();
        run(4'b0000, 4'b0000, 0, 1'b0, "post_reset");

        // Randomized runs.
        for (int r = 0; r < 14; r++) begin
            int t;
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            for (int b = 0; b < N; b++)
                for (int k = 0; k < 4; k++)
                    dly[b][k] = (t != 0 && $urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
            run(N'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), t,
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
